// File: rtl/sig_test_sequencer.sv
// Signature-test sequencer: drives two reset/sweep/capture phases (one per
// seed) around the external scrambler/adder/rotator/accumulator datapath and
// reports whether both captured signatures match their expected values.
module sig_test_sequencer #(
    parameter int RESET_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  seed_a,
    input  logic [7:0]  seed_b,
    input  logic [15:0] expected_a,
    input  logic [15:0] expected_b,
    input  logic [15:0] acc_value,
    output logic        dut_reset,
    output logic [7:0]  seed_out,
    output logic [7:0]  stimulus,
    output logic        acc_clear,
    output logic        acc_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sig_a,
    output logic [15:0] sig_b
);

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    // Reset counter is loaded with N-1 so DUT_RST lasts exactly N cycles.
    localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);

    state_t     state;
    logic       phase;
    logic [3:0] rst_cnt;
    logic       match_a;
    logic       match_b;

    // Sequencer FSM; every output is a register updated with its next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 1'b0;
            rst_cnt   <= 4'd0;
            match_a   <= 1'b0;
            match_b   <= 1'b0;
            dut_reset <= 1'b1;
            seed_out  <= 8'h00;
            stimulus  <= 8'h00;
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            sig_a     <= 16'h0000;
            sig_b     <= 16'h0000;
        end else if (abort && (state == DUT_RST || state == RUN || state == CAPTURE)) begin
            // Abort keeps captured signatures but never reports success.
            state     <= IDLE;
            dut_reset <= 1'b1;
            stimulus  <= 8'h00;
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dut_reset <= 1'b1;
                    stimulus  <= 8'h00;
                    acc_clear <= 1'b0;
                    acc_en    <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        state     <= DUT_RST;
                        phase     <= 1'b0;
                        rst_cnt   <= RST_LOAD;
                        match_a   <= 1'b0;
                        match_b   <= 1'b0;
                        pass      <= 1'b0;
                        sig_a     <= 16'h0000;
                        sig_b     <= 16'h0000;
                        seed_out  <= seed_a;
                        acc_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                DUT_RST: begin
                    if (rst_cnt == 4'd0) begin
                        state     <= RUN;
                        dut_reset <= 1'b0;
                        acc_clear <= 1'b0;
                        acc_en    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 4'd1;
                    end
                end
                RUN: begin
                    // Accumulator loads on the same edge the counter steps.
                    stimulus <= stimulus + 8'd1;
                    if (stimulus == 8'hFE) begin
                        state  <= CAPTURE;
                        acc_en <= 1'b0;
                    end
                end
                CAPTURE: begin
                    stimulus <= 8'h00;
                    if (!phase) begin
                        sig_a     <= acc_value;
                        match_a   <= (acc_value == expected_a);
                        phase     <= 1'b1;
                        seed_out  <= seed_b;
                        rst_cnt   <= RST_LOAD;
                        dut_reset <= 1'b1;
                        acc_clear <= 1'b1;
                        state     <= DUT_RST;
                    end else begin
                        sig_b     <= acc_value;
                        match_b   <= (acc_value == expected_b);
                        pass      <= match_a & (acc_value == expected_b);
                        dut_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    dut_reset <= 1'b1;
                    stimulus  <= 8'h00;
                    acc_clear <= 1'b0;
                    acc_en    <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_test_sequencer.sv
// Directed bench for sig_test_sequencer with a behavioural accumulator
// standing in for the signature datapath.
module tb_sig_test_sequencer;

    localparam int R = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  seed_a = 8'h00;
    logic [7:0]  seed_b = 8'h00;
    logic [15:0] expected_a = 16'h0000;
    logic [15:0] expected_b = 16'h0000;
    logic [15:0] acc_value = 16'h0000;
    logic        dut_reset;
    logic [7:0]  seed_out;
    logic [7:0]  stimulus;
    logic        acc_clear;
    logic        acc_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig_a;
    logic [15:0] sig_b;

    int n_checks = 0;
    int n_pass = 0;

    sig_test_sequencer #(.RESET_CYCLES(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .seed_a     (seed_a),
        .seed_b     (seed_b),
        .expected_a (expected_a),
        .expected_b (expected_b),
        .acc_value  (acc_value),
        .dut_reset  (dut_reset),
        .seed_out   (seed_out),
        .stimulus   (stimulus),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sig_a      (sig_a),
        .sig_b      (sig_b)
    );

    always #5 clk = ~clk;

    // One accumulate step: add scrambled stimulus, then rotate left by one.
    function automatic logic [15:0] acc_step(input logic [15:0] acc, input logic [7:0] stim,
                                             input logic [7:0] seed);
        logic [15:0] s;
        s = acc + {stim ^ seed, stim};
        return {s[14:0], s[15]};
    endfunction

    // Signature after a full 00..FE sweep from a cleared accumulator.
    function automatic logic [15:0] model_sig(input logic [7:0] seed);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < 255; i++) acc = acc_step(acc, 8'(i), seed);
        return acc;
    endfunction

    // Stand-in accumulator driven by the sequencer's controls.
    always @(posedge clk) begin
        if (acc_clear) acc_value <= 16'h0000;
        else if (acc_en) acc_value <= acc_step(acc_value, stimulus, seed_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":dut_reset"}, 32'(dut_reset), 32'd1);
        check({tag, ":stimulus"}, 32'(stimulus), 32'h00);
        check({tag, ":seed_out"}, 32'(seed_out), 32'h00);
        check({tag, ":acc_clear"}, 32'(acc_clear), 32'd0);
        check({tag, ":acc_en"}, 32'(acc_en), 32'd0);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":done"}, 32'(done), 32'd0);
        check({tag, ":pass"}, 32'(pass), 32'd0);
        check({tag, ":sig_a"}, 32'(sig_a), 32'h0000);
        check({tag, ":sig_b"}, 32'(sig_b), 32'h0000);
    endtask

    // Pulse start for one edge and check the immediate response.
    task automatic start_run(input string tag, input logic [7:0] sa, input logic [7:0] sb,
                             input logic [15:0] ea, input logic [15:0] eb);
        seed_a = sa;
        seed_b = sb;
        expected_a = ea;
        expected_b = eb;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
        check({tag, ":acc_clear_after_start"}, 32'(acc_clear), 32'd1);
        check({tag, ":seed_out_a"}, 32'(seed_out), 32'(sa));
    endtask

    // Count edges from the start edge until done; optional mid-run start
    // pulse and a start held high from late phase 1 onwards.
    task automatic wait_done(input string tag, input logic [7:0] sb, input bit mid_start,
                             input bit hold, output int lat);
        lat = -1;
        for (int n = 1; n <= 1500 && lat < 0; n++) begin
            if (mid_start && n == R + 100) start = 1'b1;
            else if (mid_start && n == R + 101) start = 1'b0;
            if (hold && n == 520) start = 1'b1;
            tick();
            if (n == R + 100) begin
                check({tag, ":stim_run100"}, 32'(stimulus), 32'h64);
                check({tag, ":acc_en_run"}, 32'(acc_en), 32'd1);
                check({tag, ":dut_reset_run"}, 32'(dut_reset), 32'd0);
            end
            if (n == R + 255) begin
                check({tag, ":stim_capture"}, 32'(stimulus), 32'hFF);
                check({tag, ":acc_en_capture"}, 32'(acc_en), 32'd0);
            end
            if (n == R + 257) check({tag, ":seed_out_b"}, 32'(seed_out), 32'(sb));
            if (done) begin
                lat = n;
                check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
            end
        end
        check({tag, ":latency"}, 32'(lat), 32'd522);
    endtask

    initial begin
        logic [15:0] ma, mb, mc, md;
        int lat;
        int done_cnt;
        ma = model_sig(8'hAA);
        mb = model_sig(8'hFF);
        mc = model_sig(8'h3C);
        md = model_sig(8'hC3);

        // Reset for two cycles.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");
        tick();
        check("idle_hold:busy", 32'(busy), 32'd0);

        // Matching run.
        start_run("match", 8'hAA, 8'hFF, ma, mb);
        wait_done("match", 8'hFF, 1'b0, 1'b0, lat);
        check("match:pass", 32'(pass), 32'd1);
        check("match:sig_a", 32'(sig_a), 32'(ma));
        check("match:sig_b", 32'(sig_b), 32'(mb));
        tick();
        check("match:done_pulse", 32'(done), 32'd0);
        check("match:pass_hold", 32'(pass), 32'd1);

        // Phase-1 mismatch in the lowest bit.
        start_run("mis", 8'hAA, 8'hFF, ma, mb ^ 16'h0001);
        check("mis:pass_cleared", 32'(pass), 32'd0);
        check("mis:sig_a_cleared", 32'(sig_a), 32'h0000);
        wait_done("mis", 8'hFF, 1'b0, 1'b0, lat);
        check("mis:pass", 32'(pass), 32'd0);
        check("mis:sig_a", 32'(sig_a), 32'(ma));
        check("mis:sig_b", 32'(sig_b), 32'(mb));
        tick();

        // Start ignored mid-run; start held through DONE restarts.
        start_run("hold", 8'h3C, 8'hC3, mc, md);
        wait_done("hold", 8'hC3, 1'b1, 1'b1, lat);
        check("hold:pass", 32'(pass), 32'd1);
        tick();
        check("hold:idle_busy", 32'(busy), 32'd0);
        check("hold:idle_done", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        check("hold:restart_busy", 32'(busy), 32'd1);
        check("hold:restart_acc_clear", 32'(acc_clear), 32'd1);
        check("hold:restart_pass", 32'(pass), 32'd0);
        wait_done("hold2", 8'hC3, 1'b0, 1'b0, lat);
        check("hold2:pass", 32'(pass), 32'd1);
        check("hold2:sig_b", 32'(sig_b), 32'(md));
        tick();

        // Abort in phase-1 RUN at stimulus 8'h64.
        start_run("abort", 8'hAA, 8'hFF, ma, mb);
        for (int n = 1; n <= 2 * R + 356; n++) tick();
        check("abort:stim_before", 32'(stimulus), 32'h64);
        check("abort:seed_phase1", 32'(seed_out), 32'hFF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:dut_reset", 32'(dut_reset), 32'd1);
        check("abort:acc_en", 32'(acc_en), 32'd0);
        check("abort:pass", 32'(pass), 32'd0);
        check("abort:sig_a", 32'(sig_a), 32'(ma));
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort:no_done", 32'(done_cnt), 32'd0);
        check("abort:stays_idle", 32'(busy), 32'd0);

        // Abort in IDLE is ignored alongside start.
        abort = 1'b1;
        start_run("abort_idle", 8'h3C, 8'hC3, mc, md);
        abort = 1'b0;

        // Reset during phase-0 RUN; subsequent run completes normally.
        for (int n = 1; n <= R + 50; n++) tick();
        check("rst_mid:stim_before", 32'(stimulus), 32'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_mid");
        start_run("after_rst", 8'hAA, 8'hFF, ma, mb);
        wait_done("after_rst", 8'hFF, 1'b0, 1'b0, lat);
        check("after_rst:pass", 32'(pass), 32'd1);
        check("after_rst:sig_a", 32'(sig_a), 32'(ma));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sig_test_sequencer.md
# sig_test_sequencer

Hardware sequencer for the microprocessor signature-test datapath: stimulus counter, seed-driven scrambler, adder, rotator and 16-bit accumulator. It replaces the bench-driven reset pulses and seed switching with a synthesizable controller. For each of two seeds it resets the DUT and clears the accumulator, then sweeps the stimulus counter from 8'h00 to 8'hFF. When the counter reaches full it captures the final signature, compares it against an expected value and reports pass/fail.

## Interface
Parameters:
- RESET_CYCLES, 5, number of cycles dut_reset/acc_clear are held per phase; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces all registers to reset values
- start  in  1  sampled in IDLE only; begins a two-phase test
- abort  in  1  sampled in DUT_RST/RUN/CAPTURE; returns to IDLE
- seed_a  in  8  seed for phase 0
- seed_b  in  8  seed for phase 1
- expected_a  in  16  expected phase-0 signature
- expected_b  in  16  expected phase-1 signature
- acc_value  in  16  current external accumulator output
- dut_reset  out  1  reset to microprocessor
- seed_out  out  8  seed to scrambler
- stimulus  out  8  counter value; bits [7:4] drive DUT i_pins
- acc_clear  out  1  synchronous clear to accumulator
- acc_en  out  1  accumulator load enable (counter_full_bar equivalent)
- busy  out  1  high in DUT_RST, RUN, CAPTURE
- done  out  1  one-cycle pulse on completion
- pass  out  1  both signatures matched; valid from done until next start
- sig_a, sig_b  out  16  captured signatures

## Operation
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States: IDLE, DUT_RST, RUN, CAPTURE, DONE. 1-bit phase register; 4-bit reset counter.
- IDLE: dut_reset=1, acc_clear=0, acc_en=0, stimulus=0.
  - start=1 → clear phase, pass, sig_a and sig_b; seed_out←seed_a; go to DUT_RST.
- DUT_RST: dut_reset=1, acc_clear=1, stimulus=0, for exactly RESET_CYCLES cycles, then RUN.
- RUN: dut_reset=0, acc_en=1.
  - stimulus increments by 1 each cycle.
  - At the edge where stimulus goes FE→FF, go to CAPTURE.
  - RUN therefore lasts exactly 255 cycles, with stimulus 8'h00..8'hFE.
- CAPTURE: acc_en=0, stimulus=8'hFF, lasts 1 cycle.
  - At its ending edge, acc_value is latched into sig_a (phase 0) or sig_b (phase 1), and the corresponding match bit is recorded.
  - Phase 0 → phase←1, seed_out←seed_b, go to DUT_RST.
  - Phase 1 → go to DONE.
- DONE: done=1 and pass=match_a & match_b for one cycle, then IDLE.
  - pass, sig_a and sig_b hold until the next accepted start or reset.
- Seed and expected inputs are sampled only at the points stated above. Changes at other times are ignored.
- Comparison is a full 16-bit equality check. There is no wrap or masking.

## Timing
- Reset values: state=IDLE, dut_reset=1, seed_out=8'h00, stimulus=8'h00, acc_clear=0, acc_en=0, busy=0, done=0, pass=0, sig_a=sig_b=16'h0000, phase=0.
- start sampled high at edge E0 → busy=1 and acc_clear=1 after E0.
- State enters DONE at edge E0 + 2·(RESET_CYCLES+256). With the default parameter this is E0+522.
- done is high for exactly one cycle; busy falls at the same edge done rises.
- start while busy or in DONE: ignored.
  - start held high through DONE → a new run begins at the edge after returning to IDLE.
- abort=1 while busy: next state IDLE; dut_reset=1 and acc_en=0 the following cycle.
  - pass=0; sig_a/sig_b keep whatever was captured; done is not asserted.
  - abort in IDLE or DONE: ignored.
- abort and start in the same IDLE cycle: start wins, since abort is ignored in IDLE.
- reset mid-run overrides everything and restores reset values at that edge.
- The accumulator must load on the same edge the counter increments. acc_en=0 in CAPTURE guarantees a stable acc_value when it is sampled.

## Test plan
- Apply reset for 2 cycles → all outputs at reset values; dut_reset=1, stimulus=8'h00.
- seed_a=8'hAA, seed_b=8'hFF, expected_a/expected_b from a bench reference model, pulse start → stimulus sweeps 00..FF twice, done exactly 522 cycles after start edge, pass=1, sig_a/sig_b equal model values.
- Same run with expected_b=model_b^16'h0001 → done at cycle 522, pass=0, sig_b=model_b.
- Pulse start again at cycle 100 of RUN → ignored; done still at 522. Hold start high through DONE → second run begins 1 cycle after done.
- abort at RUN stimulus=8'h64 in phase 1 → IDLE next cycle, dut_reset=1, no done, pass=0, sig_a retained.
- Assert reset during phase-0 RUN → next cycle all outputs at reset values, busy=0; a following start completes normally in 522 cycles.
